bin2bcd_dd: RTL

Parametrised sequential binary-to-BCD converter using double-dabble (add-3 / shift-left), one input bit per enabled clock.
Generalises the fixed 27-bit/8-digit shift converter:
- configurable input width and digit count
- optional two's-complement input with a sign output
- overflow detection with optional saturation
- leading-zero blanking mask for seven-segment / LED display drivers

Sits between counters or measurement logic and the display scan drivers.

---
 rtl/bin2bcd_dd.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_dd.sv
// Sequential binary-to-BCD converter (double dabble): one operand bit per enabled clock,
// optional two's-complement input, overflow detect/saturate and leading-zero blanking mask.
module bin2bcd_dd #(
  parameter int C_BIN_W  = 27,
  parameter int C_DIGITS = 8,
  parameter bit C_SIGNED = 1'b0,
  parameter bit C_SAT    = 1'b1
) (
  input  logic                    CK_i,
  input  logic                    XARST_i,
  input  logic                    EN_CK_i,
  input  logic [C_BIN_W-1:0]      DAT_i,
  input  logic                    REQ_i,
  output logic                    BUSY_o,
  output logic                    DONE_o,
  output logic [4*C_DIGITS-1:0]   QQ_o,
  output logic                    SIGN_o,
  output logic                    OVF_o,
  output logic [C_DIGITS-1:0]     LZB_o
);

  localparam int CNT_W = $clog2(C_BIN_W + 1);
  localparam int QW    = 4 * C_DIGITS;
  localparam logic [QW-1:0]       ALL9    = {C_DIGITS{4'h9}};
  localparam logic [C_DIGITS-1:0] LZB_RST = ~((C_DIGITS)'(1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  state_t               state_q;
  logic [C_BIN_W-1:0]   sr_q;
  logic [QW-1:0]        dig_q;
  logic                 ovf_q;
  logic                 sign_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 busy_q;
  logic                 done_q;
  logic [QW-1:0]        qq_q;
  logic                 sign_out_q;
  logic                 ovf_out_q;
  logic [C_DIGITS-1:0]  lzb_q;

  // Operand magnitude; negating in C_BIN_W bits makes the most negative value exact.
  logic                 neg;
  logic [C_BIN_W-1:0]   mag;
  assign neg = C_SIGNED && DAT_i[C_BIN_W-1];
  assign mag = neg ? -DAT_i : DAT_i;

  logic [QW-1:0]        dig_adj;
  logic [QW-1:0]        dig_d;
  logic [C_BIN_W-1:0]   sr_d;
  logic                 carry_out;

  for (genvar gi = 0; gi < C_DIGITS; gi++) begin : g_adj
    logic [3:0] digit;
    assign digit = dig_q[4*gi +: 4];
    assign dig_adj[4*gi +: 4] = (digit >= 4'd5 && digit <= 4'd9) ? digit + 4'd3 : digit;
  end

  // The bit leaving the top digit means the running value no longer fits.
  assign {carry_out, dig_d, sr_d} = {dig_adj, sr_q, 1'b0};

  logic [QW-1:0]        qq_d;
  logic [C_DIGITS:0]    zero_above;
  logic [C_DIGITS-1:0]  lzb_d;

  assign qq_d = (ovf_q && C_SAT) ? ALL9 : dig_q;
  assign zero_above[C_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < C_DIGITS; gi++) begin : g_lzb
    assign zero_above[gi] = zero_above[gi+1] & (qq_d[4*gi +: 4] == 4'd0);
  end

  // Digit 0 is always shown, so its blanking bit is masked off.
  assign lzb_d = zero_above[C_DIGITS-1:0] & LZB_RST;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      qq_q       <= '0;
      sign_out_q <= 1'b0;
      ovf_out_q  <= 1'b0;
      lzb_q      <= LZB_RST;
    end else if (EN_CK_i) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ_i) begin
            sr_q    <= mag;
            sign_q  <= neg;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= (CNT_W)'(C_BIN_W);
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          dig_q <= dig_d;
          sr_q  <= sr_d;
          ovf_q <= ovf_q | carry_out;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == (CNT_W)'(1)) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          qq_q       <= qq_d;
          ovf_out_q  <= ovf_q;
          sign_out_q <= sign_q;
          lzb_q      <= lzb_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY_o = busy_q;
  assign DONE_o = done_q;
  assign QQ_o   = qq_q;
  assign SIGN_o = sign_out_q;
  assign OVF_o  = ovf_out_q;
  assign LZB_o  = lzb_q;

endmodule
